// File: rtl/divider_arbiter.sv
// Round-robin arbiter sharing one signed fixed-point divider among NREQ
// requesters. A single request is accepted and issued to the divider. The
// block then waits for done, with a timeout, and holds the response for the
// granted requester until that requester accepts it.
module divider_arbiter #(
  parameter int WIDTH   = 16,
  parameter int NREQ    = 3,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic [NREQ-1:0]       req_valid_in,
  output logic [NREQ-1:0]       req_ready_out,
  input  logic [NREQ*WIDTH-1:0] req_a_in,
  input  logic [NREQ*WIDTH-1:0] req_b_in,
  output logic [NREQ-1:0]       rsp_valid_out,
  input  logic [NREQ-1:0]       rsp_ready_in,
  output logic [WIDTH-1:0]      rsp_val_out,
  output logic [2:0]            rsp_err_out,
  output logic                  div_start_out,
  output logic [WIDTH-1:0]      div_a_out,
  output logic [WIDTH-1:0]      div_b_out,
  input  logic                  div_done_in,
  input  logic                  div_valid_in,
  input  logic                  div_dbz_in,
  input  logic                  div_ovf_in,
  input  logic [WIDTH-1:0]      div_val_in
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [PW:0]   NREQ_W  = (PW+1)'(NREQ);
  localparam logic [PW-1:0] LAST_RQ = PW'(NREQ - 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [PW-1:0]     r_rr_ptr;
  logic [PW-1:0]     r_grant;
  logic [CW-1:0]     r_wait_cnt;
  logic [WIDTH-1:0]  r_div_a;
  logic [WIDTH-1:0]  r_div_b;
  logic [WIDTH-1:0]  r_rsp_val;
  logic [2:0]        r_rsp_err;

  logic [PW-1:0]     w_idx [NREQ];
  logic [WIDTH-1:0]  w_a_slice [NREQ];
  logic [WIDTH-1:0]  w_b_slice [NREQ];
  logic [PW-1:0]     w_winner;
  logic              w_found;
  logic              w_accept;
  logic              w_rsp_hs;
  logic              w_timeout;
  logic [CW-1:0]     w_cnt_inc;
  logic [PW-1:0]     w_grant_inc;

  // Ready is masked by reset so that every output reads 0 while reset is held,
  // even if requesters keep valid asserted.
  assign w_accept    = (r_state == S_IDLE) && w_found && rst_n_in;
  assign w_rsp_hs    = (r_state == S_RESP) && rsp_ready_in[r_grant];
  // The counter reaches TIMEOUT-1 on the edge that leaves WAIT, so the timeout
  // response appears TIMEOUT cycles after the start pulse.
  assign w_cnt_inc   = r_wait_cnt + 1'b1;
  assign w_timeout   = (w_cnt_inc == TO_LAST);
  assign w_grant_inc = (r_grant == LAST_RQ) ? '0 : r_grant + 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      logic [PW:0] w_sum;
      // Search position gi, counted upward from the round-robin pointer with wrap.
      assign w_sum            = {1'b0, r_rr_ptr} + (PW+1)'(gi);
      assign w_idx[gi]        = (w_sum >= NREQ_W) ? PW'(w_sum - NREQ_W) : PW'(w_sum);
      assign w_a_slice[gi]    = req_a_in[gi*WIDTH +: WIDTH];
      assign w_b_slice[gi]    = req_b_in[gi*WIDTH +: WIDTH];
      assign req_ready_out[gi] = w_accept && (w_winner == PW'(gi));
      assign rsp_valid_out[gi] = (r_state == S_RESP) && (r_grant == PW'(gi));
    end
  endgenerate

  assign div_start_out = (r_state == S_ISSUE);
  assign div_a_out     = r_div_a;
  assign div_b_out     = r_div_b;
  assign rsp_val_out   = r_rsp_val;
  assign rsp_err_out   = r_rsp_err;

  // Pick the first valid requester at or after the pointer. The loop runs
  // backwards so that the nearest position is the last one written.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid_in[w_idx[i]]) begin
        w_found  = 1'b1;
        w_winner = w_idx[i];
      end
    end
  end

  // State register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) r_state <= S_IDLE;
    else           r_state <= w_state_next;
  end

  // Next-state logic. A done in the last wait cycle wins over the timeout.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_state_next = S_ISSUE;
      S_ISSUE: w_state_next = S_WAIT;
      S_WAIT:  if (div_done_in || w_timeout) w_state_next = S_RESP;
      S_RESP:  if (w_rsp_hs) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Grant, operand, wait counter, response capture and pointer registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_rr_ptr   <= '0;
      r_grant    <= '0;
      r_wait_cnt <= '0;
      r_div_a    <= '0;
      r_div_b    <= '0;
      r_rsp_val  <= '0;
      r_rsp_err  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant <= w_winner;
            r_div_a <= w_a_slice[w_winner];
            r_div_b <= w_b_slice[w_winner];
          end
        end
        S_ISSUE: r_wait_cnt <= '0;
        S_WAIT: begin
          r_wait_cnt <= w_cnt_inc;
          if (div_done_in) begin
            r_rsp_val <= div_valid_in ? div_val_in : '0;
            r_rsp_err <= {1'b0, div_ovf_in, div_dbz_in};
          end else if (w_timeout) begin
            r_rsp_val <= '0;
            r_rsp_err <= 3'b100;
          end
        end
        S_RESP: if (w_rsp_hs) r_rr_ptr <= w_grant_inc;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_arbiter.sv
// Bench for divider_arbiter: directed scenarios plus randomized traffic. It
// uses a Q8.8 divider model with variable latency and a transaction-level
// reference that is checked against the outputs every cycle.
module tb_divider_arbiter;
  localparam int WIDTH   = 16;
  localparam int NREQ    = 3;
  localparam int TIMEOUT = 8;

  logic                  clk_in = 1'b0;
  logic                  rst_n_in = 1'b0;
  logic [NREQ-1:0]       req_valid_in = '0;
  logic [NREQ-1:0]       req_ready_out;
  logic [NREQ*WIDTH-1:0] req_a_in = '0;
  logic [NREQ*WIDTH-1:0] req_b_in = '0;
  logic [NREQ-1:0]       rsp_valid_out;
  logic [NREQ-1:0]       rsp_ready_in = '0;
  logic [WIDTH-1:0]      rsp_val_out;
  logic [2:0]            rsp_err_out;
  logic                  div_start_out;
  logic [WIDTH-1:0]      div_a_out;
  logic [WIDTH-1:0]      div_b_out;
  logic                  div_done_in = 1'b0;
  logic                  div_valid_in = 1'b0;
  logic                  div_dbz_in = 1'b0;
  logic                  div_ovf_in = 1'b0;
  logic [WIDTH-1:0]      div_val_in = '0;

  divider_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
    .req_a_in(req_a_in), .req_b_in(req_b_in),
    .rsp_valid_out(rsp_valid_out), .rsp_ready_in(rsp_ready_in),
    .rsp_val_out(rsp_val_out), .rsp_err_out(rsp_err_out),
    .div_start_out(div_start_out), .div_a_out(div_a_out), .div_b_out(div_b_out),
    .div_done_in(div_done_in), .div_valid_in(div_valid_in),
    .div_dbz_in(div_dbz_in), .div_ovf_in(div_ovf_in), .div_val_in(div_val_in)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Signed Q8.8 division, truncating toward zero.
  function automatic void qcalc(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                output logic [WIDTH-1:0] q, output logic dbz, output logic ovf);
    longint na, nb, r;
    na  = longint'($signed(a)) * 256;
    nb  = longint'($signed(b));
    dbz = (b == '0);
    ovf = 1'b0;
    q   = '0;
    if (!dbz) begin
      r = na / nb;
      if (r > 32767 || r < -32768) ovf = 1'b1;
      else q = r[WIDTH-1:0];
    end
  endfunction

  // Divider model. Mode 0 uses a random latency of 1..8, or never answers
  // 1 time in 10. Mode 1 uses the fixed latency div_fix. Mode 2 never answers.
  int div_mode = 1;
  int div_fix  = 3;
  int div_cd   = 0;
  logic [WIDTH-1:0] dm_a, dm_b;

  always @(negedge clk_in) begin
    if (div_start_out === 1'b1) begin
      dm_a = div_a_out;
      dm_b = div_b_out;
      if (div_mode == 2)                     div_cd = 0;
      else if (div_mode == 1)                div_cd = div_fix;
      else if ($urandom_range(0, 9) == 0)    div_cd = 0;
      else                                   div_cd = $urandom_range(1, 8);
    end
  end

  always @(posedge clk_in) begin
    logic [WIDTH-1:0] q;
    logic dbz, ovf;
    #1;
    div_done_in  = 1'b0;
    div_val_in   = WIDTH'($urandom);
    div_valid_in = 1'($urandom);
    div_dbz_in   = 1'($urandom);
    div_ovf_in   = 1'($urandom);
    if (div_cd > 0) begin
      div_cd--;
      if (div_cd == 0) begin
        qcalc(dm_a, dm_b, q, dbz, ovf);
        div_done_in  = 1'b1;
        div_dbz_in   = dbz;
        div_ovf_in   = ovf;
        div_valid_in = !(dbz || ovf);
        div_val_in   = (dbz || ovf) ? WIDTH'($urandom) : q;
      end
    end
  end

  // Transaction-level reference: the phase of the current transaction, the
  // granted requester, and the cycle of the start pulse.
  typedef enum int {P_IDLE, P_ISSUE, P_WAIT, P_RESP} phase_t;
  phase_t           m_phase = P_IDLE;
  int               m_ptr = 0;
  int               m_grant = 0;
  int               m_start_cyc = 0;
  int               n_starts = 0;
  logic [WIDTH-1:0] m_a = '0;
  logic [WIDTH-1:0] m_b = '0;
  logic [WIDTH-1:0] m_val = '0;
  logic [2:0]       m_err = '0;
  int               grant_log[$];
  int               waited[NREQ];

  always @(negedge clk_in) begin
    logic [NREQ-1:0] exp_ready, exp_rv;
    int win;
    cyc++;
    if (!rst_n_in) begin
      m_phase = P_IDLE;
      m_ptr = 0;
      m_a = '0;
      m_b = '0;
      m_val = '0;
      m_err = '0;
      for (int k = 0; k < NREQ; k++) waited[k] = 0;
      check("reset_outputs", {req_ready_out, rsp_valid_out, rsp_val_out, rsp_err_out,
                              div_start_out, div_a_out, div_b_out}, 64'd0);
    end else begin
      win = -1;
      if (m_phase == P_IDLE)
        for (int i = 0; i < NREQ; i++)
          if (win < 0 && req_valid_in[(m_ptr + i) % NREQ]) win = (m_ptr + i) % NREQ;
      exp_ready = '0;
      if (win >= 0) exp_ready[win] = 1'b1;
      exp_rv = '0;
      if (m_phase == P_RESP) exp_rv[m_grant] = 1'b1;
      check("req_ready", req_ready_out, exp_ready);
      check("div_start", div_start_out, m_phase == P_ISSUE);
      check("rsp_valid", rsp_valid_out, exp_rv);
      check("rsp_val", rsp_val_out, m_val);
      check("rsp_err", rsp_err_out, m_err);
      check("div_a", div_a_out, m_a);
      check("div_b", div_b_out, m_b);
      if (div_start_out === 1'b1) n_starts++;
      for (int k = 0; k < NREQ; k++) if (!req_valid_in[k]) waited[k] = 0;
      case (m_phase)
        P_IDLE: if (win >= 0) begin
          check("fairness", waited[win] <= NREQ - 1, 64'd1);
          for (int k = 0; k < NREQ; k++) if (k != win && req_valid_in[k]) waited[k]++;
          waited[win] = 0;
          m_grant = win;
          m_a = req_a_in[win*WIDTH +: WIDTH];
          m_b = req_b_in[win*WIDTH +: WIDTH];
          grant_log.push_back(win);
          m_phase = P_ISSUE;
        end
        P_ISSUE: begin
          m_start_cyc = cyc;
          m_phase = P_WAIT;
        end
        P_WAIT: begin
          if (div_done_in) begin
            m_val = div_valid_in ? div_val_in : '0;
            m_err = {1'b0, div_ovf_in, div_dbz_in};
            m_phase = P_RESP;
          end else if (cyc - m_start_cyc == TIMEOUT - 1) begin
            m_val = '0;
            m_err = 3'b100;
            m_phase = P_RESP;
          end
        end
        P_RESP: if (rsp_ready_in[m_grant]) begin
          m_ptr = (m_grant + 1) % NREQ;
          m_phase = P_IDLE;
        end
        default: ;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    rst_n_in = 1'b0;
    tick();
    tick();
    rst_n_in = 1'b1;
  endtask

  task automatic wait_grants(input int n, input string name);
    int base = grant_log.size();
    int t = 0;
    while (grant_log.size() < base + n && t < 400) begin
      tick();
      t++;
    end
    check(name, grant_log.size() >= base + n, 64'd1);
  endtask

  task automatic wait_rsp(input string name);
    int t = 0;
    while (rsp_valid_out == '0 && t < 100) begin
      tick();
      t++;
    end
    check(name, rsp_valid_out != '0, 64'd1);
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while ((m_phase != P_IDLE || div_cd != 0) && t < 400) begin
      tick();
      t++;
    end
    check(name, (m_phase == P_IDLE) && (div_cd == 0), 64'd1);
  endtask

  function automatic logic [WIDTH-1:0] rand_b();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return WIDTH'($urandom_range(1, 3));
      default: return WIDTH'($urandom);
    endcase
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n0, n;
    // Reset state
    tick();
    check("reset_state", {req_ready_out, rsp_valid_out, rsp_val_out, rsp_err_out,
                          div_start_out, div_a_out, div_b_out}, 64'd0);

    // 1: basic Q8.8 transaction, 3.0 / 2.0 = 1.5
    div_mode = 1;
    div_fix = 3;
    req_a_in[0*WIDTH +: WIDTH] = 16'h0300;
    req_b_in[0*WIDTH +: WIDTH] = 16'h0200;
    rst_n_in = 1'b1;
    n0 = n_starts;
    req_valid_in = 3'b001;
    wait_grants(1, "t1_grant_timeout");
    req_valid_in = '0;
    wait_rsp("t1_rsp_timeout");
    check("t1_rsp_valid", rsp_valid_out, 3'b001);
    check("t1_rsp_val", rsp_val_out, 16'h0180);
    check("t1_rsp_err", rsp_err_out, 3'b000);
    check("t1_start_pulses", n_starts - n0, 64'd1);
    rsp_ready_in = 3'b111;
    tick();
    rsp_ready_in = '0;
    wait_idle("t1_idle_timeout");

    // 2: round robin with all requesters valid from reset
    rst_n_in = 1'b0;
    div_mode = 0;
    for (int k = 0; k < NREQ; k++) begin
      req_a_in[k*WIDTH +: WIDTH] = WIDTH'(16'h0100 * (k + 1));
      req_b_in[k*WIDTH +: WIDTH] = 16'h0080;
    end
    req_valid_in = 3'b111;
    rsp_ready_in = 3'b111;
    tick();
    tick();
    rst_n_in = 1'b1;
    n0 = grant_log.size();
    wait_grants(6, "t2_grant_timeout");
    req_valid_in = '0;
    for (int i = 0; i < 6; i++)
      check($sformatf("t2_order_%0d", i), grant_log[n0 + i], i % NREQ);
    wait_idle("t2_idle_timeout");

    // 3: divide by zero on requester 1, then requester 2 is next
    div_mode = 1;
    div_fix = 2;
    do_reset();
    rsp_ready_in = '0;
    req_a_in[1*WIDTH +: WIDTH] = 16'h0100;
    req_b_in[1*WIDTH +: WIDTH] = 16'h0000;
    req_valid_in = 3'b010;
    wait_grants(1, "t3_grant_timeout");
    req_b_in[1*WIDTH +: WIDTH] = 16'h0100;
    req_valid_in = 3'b111;
    wait_rsp("t3_rsp_timeout");
    check("t3_rsp_valid", rsp_valid_out, 3'b010);
    check("t3_rsp_val", rsp_val_out, 16'h0000);
    check("t3_rsp_err", rsp_err_out, 3'b001);
    rsp_ready_in = 3'b111;
    wait_grants(1, "t3_next_timeout");
    req_valid_in = '0;
    check("t3_next_grant", grant_log[grant_log.size() - 1], 2);
    wait_idle("t3_idle_timeout");

    // 4: response backpressure on requester 0 while requester 1 waits
    do_reset();
    rsp_ready_in = '0;
    req_a_in[0*WIDTH +: WIDTH] = 16'h0500;
    req_b_in[0*WIDTH +: WIDTH] = 16'h0100;
    req_valid_in = 3'b011;
    wait_grants(1, "t4_grant_timeout");
    req_valid_in = 3'b010;
    wait_rsp("t4_rsp_timeout");
    for (int i = 0; i < 10; i++) begin
      check("t4_hold_valid", rsp_valid_out, 3'b001);
      check("t4_hold_val", rsp_val_out, 16'h0500);
      check("t4_hold_ready", req_ready_out, 3'b000);
      tick();
    end
    rsp_ready_in = 3'b001;
    tick();
    check("t4_ready_after_hs", req_ready_out, 3'b010);
    rsp_ready_in = 3'b111;
    wait_grants(1, "t4_grant1_timeout");
    req_valid_in = '0;
    wait_idle("t4_idle_timeout");

    // 5: divider never answers, timeout response after TIMEOUT cycles
    div_mode = 2;
    do_reset();
    rsp_ready_in = '0;
    req_valid_in = 3'b100;
    wait_grants(1, "t5_grant_timeout");
    req_valid_in = '0;
    n = 0;
    while (div_start_out !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("t5_start_seen", div_start_out, 1'b1);
    n = 0;
    while (rsp_valid_out == '0 && n < 40) begin
      tick();
      n++;
    end
    check("t5_latency", n, TIMEOUT);
    check("t5_rsp_valid", rsp_valid_out, 3'b100);
    check("t5_rsp_err", rsp_err_out, 3'b100);
    check("t5_rsp_val", rsp_val_out, 16'h0000);
    rsp_ready_in = 3'b111;
    tick();
    wait_idle("t5_idle_timeout");

    // 6: asynchronous reset during WAIT, late done must be ignored
    div_mode = 1;
    div_fix = 6;
    do_reset();
    rsp_ready_in = 3'b111;
    req_valid_in = 3'b100;
    wait_grants(1, "t6_grant_timeout");
    req_valid_in = '0;
    tick();
    tick();
    tick();
    #1;
    rst_n_in = 1'b0;
    #1;
    check("t6_async_zero", {req_ready_out, rsp_valid_out, rsp_val_out, rsp_err_out,
                            div_start_out, div_a_out, div_b_out}, 64'd0);
    tick();
    tick();
    rst_n_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("t6_no_rsp", rsp_valid_out, 3'b000);
      tick();
    end
    req_valid_in = 3'b110;
    wait_grants(1, "t6_grant2_timeout");
    req_valid_in = '0;
    check("t6_ptr_reset", grant_log[grant_log.size() - 1], 1);
    wait_idle("t6_idle_timeout");

    // Randomized traffic
    div_mode = 0;
    do_reset();
    for (int t = 0; t < 3000; t++) begin
      for (int k = 0; k < NREQ; k++) begin
        req_valid_in[k] = ($urandom_range(0, 9) < 6);
        req_a_in[k*WIDTH +: WIDTH] = WIDTH'($urandom);
        req_b_in[k*WIDTH +: WIDTH] = rand_b();
      end
      rsp_ready_in = NREQ'($urandom);
      tick();
    end
    req_valid_in = '0;
    rsp_ready_in = 3'b111;
    wait_idle("rand_idle_timeout");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/divider_arbiter.md
Name: divider_arbiter

Overview:
- Shares one fixed-point signed divider among NREQ requesters.
- Each requester gets a valid/ready request channel and a valid/ready response channel.
- The block accepts one request at a time by round-robin and drives the divider's start/operand inputs.
- It waits for the divider's done, then returns the quotient and status flags to the granted requester.
- It sits between the raycasting stages that need divisions (distance, step, texture scale) and the single divider instance.

Parameters:
- WIDTH, 16, operand/result width in bits; must match the divider.
- NREQ, 3, number of requesters (2..8).
- TIMEOUT, 64, maximum cycles to wait for div_done before an error response.

Ports:
- clk_in  input  1  system clock
- rst_n_in  input  1  asynchronous active-low reset
- req_valid_in  input  NREQ  per-requester request valid
- req_ready_out  output  NREQ  per-requester request accept (one-hot or zero)
- req_a_in  input  NREQ*WIDTH  dividends; requester k occupies bits [k*WIDTH +: WIDTH]
- req_b_in  input  NREQ*WIDTH  divisors; same packing as req_a_in
- rsp_valid_out  output  NREQ  per-requester response valid (one-hot or zero)
- rsp_ready_in  input  NREQ  per-requester response accept
- rsp_val_out  output  WIDTH  quotient, shared by all requesters
- rsp_err_out  output  3  {timeout, ovf, dbz}, shared by all requesters
- div_start_out  output  1  divider start pulse
- div_a_out  output  WIDTH  divider dividend, registered
- div_b_out  output  WIDTH  divider divisor, registered
- div_done_in  input  1  divider done, one-cycle pulse
- div_valid_in  input  1  divider result valid
- div_dbz_in  input  1  divider divide-by-zero flag
- div_ovf_in  input  1  divider overflow flag
- div_val_in  input  WIDTH  divider quotient

Behaviour:
- Reset (asynchronous, rst_n_in=0):
  - state=IDLE, rr_ptr=0, grant=0, wait counter=0.
  - All outputs are 0: req_ready_out, rsp_valid_out, rsp_val_out, rsp_err_out, div_start_out, div_a_out, div_b_out.
  - Reset asserted mid-operation abandons the transaction silently; no response is produced.
  - Any divider done arriving after reset release while in IDLE is ignored.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - The winner is the first k with req_valid_in[k]=1, searching from rr_ptr upward with wrap (mod NREQ).
  - req_ready_out[winner]=1 combinationally in the same cycle; all other ready bits are 0.
  - The handshake completes on that clock edge: latch grant=winner, div_a_out=req_a slice, div_b_out=req_b slice, then go to ISSUE.
  - With no valid request, stay in IDLE.
  - req_ready_out is 0 in every state other than IDLE.
- ISSUE:
  - div_start_out=1 for exactly one cycle; clear the wait counter; go to WAIT.
- WAIT:
  - The counter increments every cycle.
  - On div_done_in=1, capture the response:
    - rsp_val_out = div_valid_in ? div_val_in : 0.
    - rsp_err_out = {0, div_ovf_in, div_dbz_in}.
    - Go to RESP.
  - If the counter reaches TIMEOUT-1 without div_done_in, capture rsp_val_out=0 and rsp_err_out=3'b100, then go to RESP.
  - If done and timeout occur in the same cycle, done wins.
- RESP:
  - rsp_valid_out[grant]=1 and is held, with rsp_val_out and rsp_err_out stable, until rsp_ready_in[grant]=1.
  - On that edge: rsp_valid_out=0, rr_ptr=(grant+1) mod NREQ, go to IDLE.
  - rsp_ready_in bits of non-granted requesters are ignored.
- Throughput and latency:
  - One division in flight at a time.
  - Minimum request-accept to rsp_valid latency = divider latency + 2 cycles.
  - A new grant can occur in the cycle after the response handshake.
- Fairness:
  - A requester that is continuously valid waits at most NREQ-1 other transactions.
  - A requester may drop req_valid before it is granted with no effect.
- Registered outputs:
  - div_a_out and div_b_out are held from grant until the next grant.
  - rsp_val_out and rsp_err_out are held until the next capture.

Test Plan:
1. Basic transaction, NREQ=3, WIDTH=16 Q8.8: req 0 with a=0x0300, b=0x0200 → one div_start_out pulse; rsp_valid_out=3'b001, rsp_val_out=0x0180, rsp_err_out=0.
2. Round-robin: all three requesters valid continuously from reset → grant order 0,1,2,0,1,2; each receives its own quotient; req_ready_out is never multi-hot.
3. Divide-by-zero: req 1 with a=0x0100, b=0 → rsp_valid_out[1]=1, rsp_val_out=0, rsp_err_out=3'b001; the next grant goes to requester 2.
4. Backpressure: hold rsp_ready_in[0]=0 for 10 cycles with req 1 valid → rsp_valid_out[0] and its data stay stable; req_ready_out[1] stays 0 until cycle 11 and rises in the cycle after the response handshake.
5. Timeout: TIMEOUT=8, divider model never asserts done → rsp_err_out=3'b100 and rsp_valid_out rises exactly 8 cycles after div_start_out.
6. Async reset in WAIT: drop rsp_n_in mid-cycle → all outputs 0 immediately, before the next edge; after release, rr_ptr=0 and a late div_done_in produces no response.
